// File: rtl/axi_mem_responder_pkg.sv
// Shared types and constants for the AXI-style memory responder.
//   axi_resp_state_t        : responder FSM states
//   AXI_LEN_WIDTH           : width of ARLEN/AWLEN (beat count, not minus-one)
//   MEM_DEFAULT_INDEX_WIDTH : default log2 depth of the backing store in words
package axi_mem_responder_pkg;

    localparam int unsigned AXI_LEN_WIDTH           = 4;
    localparam int unsigned MEM_DEFAULT_INDEX_WIDTH = 12;
    localparam int unsigned AXI_ID_WIDTH            = 4;
    localparam int unsigned AXI_ADDR_WIDTH          = 32;
    localparam int unsigned AXI_DATA_WIDTH          = 32;

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdData,
        StWrData,
        StWrResp
    } axi_resp_state_t;

endpackage

// File: rtl/axi_mem_responder_cache_bank.sv
// Backing store: one write port, one synchronous read port. Contents are not reset.
//   clk_i                 : clock
//   rd_en_i / rd_addr_i   : read request; rd_data_o updates on the next edge, holds otherwise
//   wr_en_i / wr_addr_i / wr_data_i : write port
module axi_mem_responder_cache_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI-style slave memory: serves one read or write burst at a time.
//   clk, rst_n              : clock, asynchronous active-low reset
//   s_ar*                   : read address channel (ARREADY driven only in idle, when granted)
//   s_r*                    : read data channel, first beat 1+READ_LATENCY cycles after AR
//   s_aw*, s_w*             : write address / data channels
//   s_b*                    : single write response per burst
//   protocol_err_o          : sticky, WLAST disagreed with the counted final beat
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_INDEX_WIDTH = MEM_DEFAULT_INDEX_WIDTH,
    parameter int unsigned READ_LATENCY    = 2,
    parameter int unsigned LEN_WIDTH       = AXI_LEN_WIDTH,
    parameter int unsigned ID_WIDTH        = AXI_ID_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_arvalid_i,
    input  logic [ID_WIDTH-1:0]       s_arid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr_i,
    input  logic [LEN_WIDTH-1:0]      s_arlen_i,
    output logic                      s_arready_o,
    output logic                      s_rvalid_o,
    output logic [ID_WIDTH-1:0]       s_rid_o,
    output logic [AXI_DATA_WIDTH-1:0] s_rdata_o,
    output logic                      s_rlast_o,
    input  logic                      s_rready_i,
    input  logic                      s_awvalid_i,
    input  logic [ID_WIDTH-1:0]       s_awid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr_i,
    input  logic [LEN_WIDTH-1:0]      s_awlen_i,
    output logic                      s_awready_o,
    input  logic                      s_wvalid_i,
    input  logic [ID_WIDTH-1:0]       s_wid_i,
    input  logic [AXI_DATA_WIDTH-1:0] s_wdata_i,
    input  logic                      s_wlast_i,
    output logic                      s_wready_o,
    output logic                      s_bvalid_o,
    output logic [ID_WIDTH-1:0]       s_bid_o,
    input  logic                      s_bready_i,
    output logic                      protocol_err_o
);

    localparam logic [LEN_WIDTH-1:0]       OneBeat  = LEN_WIDTH'(1);
    localparam logic [MEM_INDEX_WIDTH-1:0] OneIdx   = MEM_INDEX_WIDTH'(1);
    localparam logic [3:0]                 WaitInit = 4'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

    axi_resp_state_t             state_q, state_d;
    logic                        prio_wr_q, prio_wr_d;
    logic [ID_WIDTH-1:0]         id_q, id_d;
    logic [MEM_INDEX_WIDTH-1:0]  idx_q, idx_d;
    logic [LEN_WIDTH-1:0]        beats_q, beats_d;
    logic [3:0]                  wait_q, wait_d;
    logic                        err_q, err_d;

    logic                        rd_en;
    logic [MEM_INDEX_WIDTH-1:0]  rd_idx;
    logic                        wr_en;
    logic                        grant_wr, grant_rd, last_beat;
    logic [MEM_INDEX_WIDTH-1:0]  ar_idx, aw_idx;
    logic [LEN_WIDTH-1:0]        ar_beats, aw_beats;

    // Upper address bits alias; WID is not checked.
    logic unused_bits;
    assign unused_bits = ^{s_araddr_i, s_awaddr_i, s_wid_i};

    assign ar_idx   = s_araddr_i[2 +: MEM_INDEX_WIDTH];
    assign aw_idx   = s_awaddr_i[2 +: MEM_INDEX_WIDTH];
    // LEN=0 is treated as a single beat.
    assign ar_beats = (s_arlen_i == '0) ? OneBeat : s_arlen_i;
    assign aw_beats = (s_awlen_i == '0) ? OneBeat : s_awlen_i;

    always_comb begin
        state_d     = state_q;
        prio_wr_d   = prio_wr_q;
        id_d        = id_q;
        idx_d       = idx_q;
        beats_d     = beats_q;
        wait_d      = wait_q;
        err_d       = err_q;
        rd_en       = 1'b0;
        rd_idx      = idx_q;
        wr_en       = 1'b0;
        grant_wr    = 1'b0;
        grant_rd    = 1'b0;
        last_beat   = (beats_q == OneBeat);
        s_arready_o = 1'b0;
        s_awready_o = 1'b0;
        s_rvalid_o  = 1'b0;
        s_rlast_o   = 1'b0;
        s_wready_o  = 1'b0;
        s_bvalid_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Readies are gated by reset so nothing handshakes while held in reset.
                grant_wr    = rst_n && s_awvalid_i && (!s_arvalid_i || prio_wr_q);
                grant_rd    = rst_n && s_arvalid_i && !grant_wr;
                s_awready_o = grant_wr;
                s_arready_o = grant_rd;
                if (s_awvalid_i && s_arvalid_i) begin
                    prio_wr_d = !prio_wr_q;
                end
                if (grant_wr) begin
                    id_d    = s_awid_i;
                    idx_d   = aw_idx;
                    beats_d = aw_beats;
                    state_d = StWrData;
                end else if (grant_rd) begin
                    id_d    = s_arid_i;
                    idx_d   = ar_idx;
                    beats_d = ar_beats;
                    wait_d  = WaitInit;
                    if (READ_LATENCY == 0) begin
                        rd_en   = 1'b1;
                        rd_idx  = ar_idx;
                        state_d = StRdData;
                    end else begin
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                // First word is fetched in the last wait cycle so it is ready on RD_DATA entry.
                if (wait_q == '0) begin
                    rd_en   = 1'b1;
                    state_d = StRdData;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            StRdData: begin
                s_rvalid_o = 1'b1;
                s_rlast_o  = last_beat;
                if (s_rready_i) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        // Prefetch the next word so beats stream with RREADY held high.
                        idx_d   = idx_q + OneIdx;
                        beats_d = beats_q - OneBeat;
                        rd_en   = 1'b1;
                        rd_idx  = idx_q + OneIdx;
                    end
                end
            end
            StWrData: begin
                s_wready_o = 1'b1;
                if (s_wvalid_i) begin
                    wr_en = 1'b1;
                    if (s_wlast_i != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = StWrResp;
                    end else begin
                        idx_d   = idx_q + OneIdx;
                        beats_d = beats_q - OneBeat;
                    end
                end
            end
            StWrResp: begin
                s_bvalid_o = 1'b1;
                if (s_bready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            prio_wr_q <= 1'b1;
            id_q      <= '0;
            idx_q     <= '0;
            beats_q   <= '0;
            wait_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_wr_q <= prio_wr_d;
            id_q      <= id_d;
            idx_q     <= idx_d;
            beats_q   <= beats_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
        end
    end

    assign s_rid_o        = id_q;
    assign s_bid_o        = id_q;
    assign protocol_err_o = err_q;

    axi_mem_responder_cache_bank #(
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .ADDR_WIDTH (MEM_INDEX_WIDTH)
    ) u_bank (
        .clk_i     (clk),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_idx),
        .rd_data_o (s_rdata_o),
        .wr_en_i   (wr_en),
        .wr_addr_i (idx_q),
        .wr_data_i (s_wdata_i)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
module tb_axi_mem_responder;

    localparam int DEPTH = 4096;
    localparam int LAT   = 2;

    logic        clk, rst_n;
    logic        arvalid, arready, rvalid, rlast, rready;
    logic [3:0]  arid, arlen, rid;
    logic [31:0] araddr, rdata;
    logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready, perr;
    logic [3:0]  awid, awlen, wid, bid;
    logic [31:0] awaddr, wdata;

    axi_mem_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_arvalid_i    (arvalid),
        .s_arid_i       (arid),
        .s_araddr_i     (araddr),
        .s_arlen_i      (arlen),
        .s_arready_o    (arready),
        .s_rvalid_o     (rvalid),
        .s_rid_o        (rid),
        .s_rdata_o      (rdata),
        .s_rlast_o      (rlast),
        .s_rready_i     (rready),
        .s_awvalid_i    (awvalid),
        .s_awid_i       (awid),
        .s_awaddr_i     (awaddr),
        .s_awlen_i      (awlen),
        .s_awready_o    (awready),
        .s_wvalid_i     (wvalid),
        .s_wid_i        (wid),
        .s_wdata_i      (wdata),
        .s_wlast_i      (wlast),
        .s_wready_o     (wready),
        .s_bvalid_o     (bvalid),
        .s_bid_o        (bid),
        .s_bready_i     (bready),
        .protocol_err_o (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model
    int unsigned model_mem [int];
    bit          model_err;
    bit          model_prio_wr;

    int unsigned w_data [$];
    int unsigned r_data [$];
    bit          r_last [$];
    int          r_lat, r_stall_bad, r_gaps, r_leak, r_id_bad;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic int beats_of(input int len);
        return (len == 0) ? 1 : len;
    endfunction

    task automatic idle_inputs();
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; rready = 0;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0;
        wvalid = 0; wid = 0; wdata = 0; wlast = 0; bready = 0;
    endtask

    task automatic send_aw(input logic [31:0] addr, input int len, input logic [3:0] id,
                           output int waits, output bit ok);
        @(negedge clk);
        awvalid = 1; awaddr = addr; awlen = len[3:0]; awid = id;
        waits = 0; ok = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (awready) begin ok = 1; break; end
            @(negedge clk);
            waits++;
        end
        if (ok) @(posedge clk);
        #1 awvalid = 0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input int len, input logic [3:0] id,
                           output int waits, output bit ok);
        @(negedge clk);
        arvalid = 1; araddr = addr; arlen = len[3:0]; arid = id;
        waits = 0; ok = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (arready) begin ok = 1; break; end
            @(negedge clk);
            waits++;
        end
        if (ok) @(posedge clk);
        #1 arvalid = 0;
    endtask

    // Sends w_data; WLAST raised on beat number wlast_beat (1-based). Counts ARREADY seen high.
    task automatic send_w(input int wlast_beat, output int accepted, output int ar_leak);
        accepted = 0; ar_leak = 0;
        for (int b = 0; b < w_data.size(); b++) begin
            @(negedge clk);
            wvalid = 1; wdata = w_data[b]; wid = 0; wlast = (b + 1 == wlast_beat);
            for (int i = 0; i < 100; i++) begin
                #1;
                if (arready) ar_leak++;
                if (wready) begin accepted++; break; end
                @(negedge clk);
            end
            @(posedge clk);
            #1 wvalid = 0; wlast = 0;
        end
    endtask

    task automatic recv_b(output logic [3:0] id, output bit ok, output int ar_leak);
        @(negedge clk);
        bready = 1; ok = 0; ar_leak = 0; id = 'x;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (arready) ar_leak++;
            if (bvalid) begin ok = 1; id = bid; break; end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1 bready = 0;
    endtask

    // mode 0: RREADY always high; 1: pattern 1,0,0,1; 2: random
    task automatic recv_r(input int n, input int mode, input logic [3:0] exp_id);
        int got = 0; int neg = 0; int k = 0; bit prev_stall = 0;
        logic [31:0] pd; logic pl;
        r_data.delete(); r_last.delete();
        r_lat = -1; r_stall_bad = 0; r_gaps = 0; r_leak = 0; r_id_bad = 0;
        pd = 0; pl = 0;
        while (got < n && neg < 400) begin
            @(negedge clk);
            neg++;
            case (mode)
                0:       rready = 1;
                1:       rready = (k % 4 == 0) || (k % 4 == 3);
                default: rready = (r_lat < 0) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            #1;
            if (awready) r_leak++;
            if (rvalid) begin
                if (r_lat < 0) r_lat = neg;
                if (rid !== exp_id) r_id_bad++;
                if (prev_stall && (rdata !== pd || rlast !== pl)) r_stall_bad++;
                if (rready) begin
                    r_data.push_back(rdata); r_last.push_back(rlast);
                    got++; prev_stall = 0;
                end else begin
                    prev_stall = 1; pd = rdata; pl = rlast;
                end
            end else begin
                if (prev_stall) r_stall_bad++;
                if (r_lat >= 0) r_gaps++;
                prev_stall = 0;
            end
            if (r_lat >= 0) k++;
            @(posedge clk);
        end
        #1 rready = 0;
    endtask

    // ---------------------------------------------------------------- tests

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (3) @(negedge clk);
        arvalid = 1; awvalid = 1; wvalid = 1; rready = 1; bready = 1;
        #1;
        checks++;
        if ({arready, awready, rvalid, rlast, wready, bvalid, perr} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {arready, awready, rvalid, rlast, wready, bvalid, perr});
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        model_err = 0; model_prio_wr = 1;
        #1;
        checks++;
        if ({arready, awready, rvalid, rlast, wready, bvalid, perr} !== 7'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got %b required 0000000",
                     {arready, awready, rvalid, rlast, wready, bvalid, perr});
        end
    endtask

    // Shared flow: write burst with correct WLAST, then read back and compare with the model.
    task automatic test_basic();
        int waits, acc, leak; bit ok; logic [3:0] b_id;
        w_data.delete();
        for (int i = 0; i < 4; i++) w_data.push_back(32'hA0 + i);
        send_aw(32'h100, 4, 4'h0, waits, ok);
        send_w(4, acc, leak);
        for (int i = 0; i < 4; i++) model_mem[(idx_of(32'h100) + i) % DEPTH] = w_data[i];
        recv_b(b_id, ok, leak);
        checks++;
        if (!ok || acc != 4 || b_id !== 4'h0) begin
            failures++;
            $display("FAIL basic_write: got ok=%0d beats=%0d bid=%0h required ok=1 beats=4 bid=0",
                     ok, acc, b_id);
        end
        @(negedge clk); #1;
        checks++;
        if (bvalid !== 1'b0 || perr !== model_err) begin
            failures++;
            $display("FAIL basic_single_b: got bvalid=%b perr=%b required 0 %b", bvalid, perr, model_err);
        end
        send_ar(32'h100, 4, 4'h5, waits, ok);
        recv_r(4, 0, 4'h5);
        checks++;
        if (r_lat != LAT + 1) begin
            failures++;
            $display("FAIL basic_latency: got %0d required %0d", r_lat, LAT + 1);
        end
        checks++;
        if (r_data.size() != 4 || r_gaps != 0 || r_id_bad != 0) begin
            failures++;
            $display("FAIL basic_read_stream: got beats=%0d gaps=%0d idbad=%0d required 4 0 0",
                     r_data.size(), r_gaps, r_id_bad);
        end
        for (int i = 0; i < r_data.size(); i++) begin
            checks++;
            if (r_data[i] !== 32'hA0 + i || r_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL basic_beat%0d: got data=%0h last=%b required %0h %b",
                         i, r_data[i], r_last[i], 32'hA0 + i, (i == 3));
            end
        end
    endtask

    task automatic test_rready_stall();
        int waits, acc, leak; bit ok; logic [3:0] b_id; int base;
        logic [31:0] addr;
        base = $urandom_range(0, DEPTH - 5);
        addr = 32'(base * 4);
        w_data.delete();
        for (int i = 0; i < 4; i++) w_data.push_back($urandom);
        send_aw(addr, 4, 4'h3, waits, ok);
        send_w(4, acc, leak);
        for (int i = 0; i < 4; i++) model_mem[(base + i) % DEPTH] = w_data[i];
        recv_b(b_id, ok, leak);
        send_ar(addr, 4, 4'h9, waits, ok);
        recv_r(4, 1, 4'h9);
        checks++;
        if (r_stall_bad != 0 || r_data.size() != 4) begin
            failures++;
            $display("FAIL stall_stable: got unstable=%0d beats=%0d required 0 4",
                     r_stall_bad, r_data.size());
        end
        for (int i = 0; i < r_data.size(); i++) begin
            checks++;
            if (r_data[i] !== model_mem[(base + i) % DEPTH] || r_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL stall_beat%0d: got %0h/%b required %0h/%b", i, r_data[i],
                         r_last[i], model_mem[(base + i) % DEPTH], (i == 3));
            end
        end
    endtask

    task automatic test_arbitration();
        int acc, leak, leak2; bit ok; logic [3:0] b_id; int base;
        logic [1:0] exp_ready;
        base = 200;
        // Pair 1: both valid together, address shared so the read sees the new data.
        w_data.delete();
        for (int i = 0; i < 3; i++) w_data.push_back($urandom);
        @(negedge clk);
        awvalid = 1; awaddr = 32'(base * 4); awlen = 3; awid = 4'h1;
        arvalid = 1; araddr = 32'(base * 4); arlen = 3; arid = 4'h2;
        #1;
        exp_ready = model_prio_wr ? 2'b10 : 2'b01;
        model_prio_wr = !model_prio_wr;
        checks++;
        if ({awready, arready} !== exp_ready) begin
            failures++;
            $display("FAIL arb_pair1: got aw/ar ready=%b required %b", {awready, arready}, exp_ready);
        end
        @(posedge clk); #1 awvalid = 0;
        send_w(3, acc, leak);
        for (int i = 0; i < 3; i++) model_mem[base + i] = w_data[i];
        recv_b(b_id, ok, leak2);
        checks++;
        if (leak + leak2 != 0 || b_id !== 4'h1) begin
            failures++;
            $display("FAIL arb_ar_blocked: got arready_cycles=%0d bid=%0h required 0 1",
                     leak + leak2, b_id);
        end
        @(negedge clk); #1;
        checks++;
        if (arready !== 1'b1) begin
            failures++;
            $display("FAIL arb_ar_after_b: got arready=%b required 1", arready);
        end
        @(posedge clk); #1 arvalid = 0;
        recv_r(3, 0, 4'h2);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (r_data.size() != 3 || r_data[i] !== model_mem[base + i]) begin
                failures++;
                $display("FAIL arb_raw_beat%0d: got %0h required %0h", i,
                         (r_data.size() > i) ? r_data[i] : 0, model_mem[base + i]);
            end
        end
        // Pair 2: priority toggled, read goes first.
        w_data.delete();
        for (int i = 0; i < 2; i++) w_data.push_back($urandom);
        @(negedge clk);
        awvalid = 1; awaddr = 32'((base + 10) * 4); awlen = 2; awid = 4'h7;
        arvalid = 1; araddr = 32'(base * 4); arlen = 2; arid = 4'h6;
        #1;
        exp_ready = model_prio_wr ? 2'b10 : 2'b01;
        model_prio_wr = !model_prio_wr;
        checks++;
        if ({awready, arready} !== exp_ready) begin
            failures++;
            $display("FAIL arb_pair2: got aw/ar ready=%b required %b", {awready, arready}, exp_ready);
        end
        @(posedge clk); #1 arvalid = 0;
        recv_r(2, 0, 4'h6);
        checks++;
        if (r_leak != 0 || r_data.size() != 2 || r_data[0] !== model_mem[base]
            || r_data[1] !== model_mem[base + 1]) begin
            failures++;
            $display("FAIL arb_pair2_read: got awready_cycles=%0d beats=%0d required 0 2",
                     r_leak, r_data.size());
        end
        @(negedge clk); #1;
        checks++;
        if (awready !== 1'b1) begin
            failures++;
            $display("FAIL arb_aw_after_r: got awready=%b required 1", awready);
        end
        @(posedge clk); #1 awvalid = 0;
        send_w(2, acc, leak);
        for (int i = 0; i < 2; i++) model_mem[base + 10 + i] = w_data[i];
        recv_b(b_id, ok, leak);
        checks++;
        if (!ok || b_id !== 4'h7) begin
            failures++;
            $display("FAIL arb_pair2_b: got ok=%0d bid=%0h required 1 7", ok, b_id);
        end
    endtask

    task automatic test_wrap();
        int waits, acc, leak; bit ok; logic [3:0] b_id;
        logic [31:0] addr;
        // Upper address bits set to exercise aliasing.
        addr = 32'((DEPTH - 2) * 4) | 32'h0010_0000;
        w_data.delete();
        for (int i = 0; i < 4; i++) w_data.push_back($urandom);
        send_aw(addr, 4, 4'hC, waits, ok);
        send_w(4, acc, leak);
        for (int i = 0; i < 4; i++) model_mem[(idx_of(addr) + i) % DEPTH] = w_data[i];
        recv_b(b_id, ok, leak);
        send_ar(32'h0, 2, 4'h1, waits, ok);
        recv_r(2, 0, 4'h1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (r_data.size() != 2 || r_data[i] !== w_data[i + 2]) begin
                failures++;
                $display("FAIL wrap_index%0d: got %0h required %0h", i,
                         (r_data.size() > i) ? r_data[i] : 0, w_data[i + 2]);
            end
        end
        send_ar(32'((DEPTH - 2) * 4), 4, 4'h2, waits, ok);
        recv_r(4, 2, 4'h2);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (r_data.size() != 4 || r_data[i] !== model_mem[(DEPTH - 2 + i) % DEPTH]) begin
                failures++;
                $display("FAIL wrap_readback%0d: got %0h required %0h", i,
                         (r_data.size() > i) ? r_data[i] : 0, model_mem[(DEPTH - 2 + i) % DEPTH]);
            end
        end
    endtask

    task automatic test_wlast_err();
        int waits, acc, leak; bit ok; logic [3:0] b_id;
        w_data.delete();
        for (int i = 0; i < 4; i++) w_data.push_back($urandom);
        send_aw(32'h800, 4, 4'hE, waits, ok);
        send_w(2, acc, leak);
        for (int b = 1; b <= 4; b++) if ((b == 2) != (b == 4)) model_err = 1;
        for (int i = 0; i < 4; i++) model_mem[idx_of(32'h800) + i] = w_data[i];
        recv_b(b_id, ok, leak);
        @(negedge clk); #1;
        checks++;
        if (acc != 4 || !ok || b_id !== 4'hE || bvalid !== 1'b0 || perr !== model_err) begin
            failures++;
            $display("FAIL wlast_err: got beats=%0d b=%0d bid=%0h extra_b=%b err=%b required 4 1 e 0 %b",
                     acc, ok, b_id, bvalid, perr, model_err);
        end
        w_data.delete();
        for (int i = 0; i < 2; i++) w_data.push_back($urandom);
        send_aw(32'h900, 2, 4'h4, waits, ok);
        send_w(2, acc, leak);
        for (int i = 0; i < 2; i++) model_mem[idx_of(32'h900) + i] = w_data[i];
        recv_b(b_id, ok, leak);
        #1;
        checks++;
        if (perr !== model_err) begin
            failures++;
            $display("FAIL wlast_err_sticky: got %b required %b", perr, model_err);
        end
    endtask

    task automatic test_random();
        int waits, acc, leak; bit ok; logic [3:0] b_id, id;
        int base, len, n; logic [31:0] addr;
        for (int it = 0; it < 8; it++) begin
            base = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(0, 15);
            n    = beats_of(len);
            id   = 4'($urandom);
            addr = {$urandom_range(0, 15), 2'b00} << (12 + 2) | 32'(base * 4);
            w_data.delete();
            for (int i = 0; i < n; i++) w_data.push_back($urandom);
            send_aw(addr, len, id, waits, ok);
            send_w(n, acc, leak);
            for (int i = 0; i < n; i++) model_mem[(base + i) % DEPTH] = w_data[i];
            recv_b(b_id, ok, leak);
            checks++;
            if (!ok || acc != n || b_id !== id) begin
                failures++;
                $display("FAIL rand%0d_write: got ok=%0d beats=%0d bid=%0h required 1 %0d %0h",
                         it, ok, acc, b_id, n, id);
            end
            send_ar(32'(base * 4), len, ~id, waits, ok);
            recv_r(n, 2, ~id);
            checks++;
            if (r_data.size() != n || r_stall_bad != 0 || r_id_bad != 0 || r_lat != LAT + 1) begin
                failures++;
                $display("FAIL rand%0d_read: got beats=%0d unstable=%0d idbad=%0d lat=%0d required %0d 0 0 %0d",
                         it, r_data.size(), r_stall_bad, r_id_bad, r_lat, n, LAT + 1);
            end
            for (int i = 0; i < r_data.size(); i++) begin
                checks++;
                if (r_data[i] !== model_mem[(base + i) % DEPTH] || r_last[i] !== (i == n - 1)) begin
                    failures++;
                    $display("FAIL rand%0d_beat%0d: got %0h/%b required %0h/%b", it, i, r_data[i],
                             r_last[i], model_mem[(base + i) % DEPTH], (i == n - 1));
                end
            end
        end
        checks++;
        if (perr !== model_err) begin
            failures++;
            $display("FAIL rand_err_flag: got %b required %b", perr, model_err);
        end
    endtask

    task automatic test_reset_mid_read();
        int waits, neg; bit ok, seen;
        send_ar(32'h100, 4, 4'h8, waits, ok);
        neg = 0; seen = 0;
        while (!seen && neg < 50) begin
            @(negedge clk);
            neg++;
            rready = 1;
            #1;
            if (rvalid) seen = 1;
        end
        @(negedge clk);
        rready = 0;
        #1;
        checks++;
        if (!seen || rvalid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_beat2_valid: got seen=%0d rvalid=%b required 1 1", seen, rvalid);
        end
        #2 rst_n = 0;
        #1;
        model_err = 0; model_prio_wr = 1;
        checks++;
        if ({rvalid, rlast, bvalid, wready, perr} !== 5'b0) begin
            failures++;
            $display("FAIL midrst_async_drop: got %b required 00000", {rvalid, rlast, bvalid, wready, perr});
        end
        @(negedge clk);
        rst_n = 1;
        send_ar(32'h100, 4, 4'h3, waits, ok);
        checks++;
        if (!ok || waits != 0) begin
            failures++;
            $display("FAIL midrst_ar_first_cycle: got ok=%0d waits=%0d required 1 0", ok, waits);
        end
        recv_r(4, 0, 4'h3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (r_data.size() != 4 || r_data[i] !== model_mem[idx_of(32'h100) + i]) begin
                failures++;
                $display("FAIL midrst_readback%0d: got %0h required %0h", i,
                         (r_data.size() > i) ? r_data[i] : 0, model_mem[idx_of(32'h100) + i]);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_rready_stall();
        test_arbitration();
        test_wrap();
        test_wlast_err();
        test_random();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
AXI-style slave memory model/controller that terminates the burst traffic issued by the cache masters (d_cache refill/flush, i_cache refill). It accepts one read or write burst at a time and stores words in an internal synchronous-read array. It returns read beats after a programmable latency and issues a single write response per write burst. It sits on the memory side of the cache/memory AXI interfaces and is used both in simulation and for on-chip memory.

Parameters:
MEM_INDEX_WIDTH, 12, log2 of memory depth in 32-bit words.
READ_LATENCY, 2, idle cycles between AR handshake and first R beat (0..15).
LEN_WIDTH, 4, width of ARLEN/AWLEN fields.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
s_read_address  axi_read_address.slave  -  ARVALID/ARID/ARADDR/ARLEN in, ARREADY out
s_read_data  axi_read_data.slave  -  RVALID/RID/RDATA/RLAST out, RREADY in
s_write_address  axi_write_address.slave  -  AWVALID/AWID/AWADDR/AWLEN in, AWREADY out
s_write_data  axi_write_data.slave  -  WVALID/WID/WDATA/WLAST in, WREADY out
s_write_response  axi_write_response.slave  -  BVALID/BID out, BREADY in
protocol_err  output  1  sticky: WLAST did not coincide with final counted beat

Behaviour:
- Clock clk; reset rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, every VALID/READY output=0, RLAST=0, protocol_err=0, priority bit=write-first. Memory contents are not reset.
- LEN convention: ARLEN/AWLEN = number of beats (codebase convention, not AXI minus-one). LEN=0 is treated as 1 beat.
- Addressing: word index = ADDR[2 +: MEM_INDEX_WIDTH]. Upper bits are ignored (aliasing). Index increments by 1 per beat and wraps modulo depth.
- States: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.
- IDLE:
  - ARREADY/AWREADY are driven combinationally, only in IDLE, and only for the granted channel. At most one address handshake per cycle.
  - Arbitration when both AWVALID and ARVALID: serve the channel indicated by the priority bit, then toggle it. A single requester is served immediately.
  - On AR handshake: capture ID, index, beat count. Go to RD_WAIT, or to RD_DATA directly if READ_LATENCY=0.
  - On AW handshake: capture ID, index, beat count. Go to WR_DATA.
- RD_WAIT: counts READ_LATENCY cycles; the array read of the first word is issued in the last wait cycle.
- RD_DATA:
  - First RVALID appears exactly 1+READ_LATENCY cycles after the AR handshake cycle.
  - RVALID stays high and RDATA/RID/RLAST stay stable until RREADY.
  - On each RVALID&RREADY: advance index and prefetch the next word, so back-to-back beats go out with RREADY held high.
  - RLAST=1 only on the final beat. After the final handshake, go to IDLE the next cycle.
- WR_DATA:
  - WREADY=1. Each WVALID&WREADY writes WDATA to the current index and advances the index.
  - The beat counter alone ends the burst; WLAST does not.
  - If WLAST disagrees with final-beat status on any beat, set protocol_err (cleared only by reset).
  - After the final beat, go to WR_RESP.
- WR_RESP: BVALID=1, BID=captured AWID, held until BREADY, then IDLE. An AR pending during a write waits (ARREADY=0).
- Read-after-write to the same address in consecutive bursts returns the new data (the write completes before B, and B precedes any new grant).
- Reset asserted mid-burst: immediate return to IDLE, outputs drop asynchronously, the partial write burst remains in memory, and no B is issued.

Decomposition:
- mips_core_pkg gains:
  - axi_resp_state_t enum (five states above)
  - AXI_LEN_WIDTH constant
  - MEM_DEFAULT_INDEX_WIDTH constant
- Backing store reuses the existing cache_bank: DATA_WIDTH=32, ADDR_WIDTH=MEM_INDEX_WIDTH, synchronous read, one write port.
- No other sub-module.

Test Plan:
- Write 4 beats 0xA0..0xA3 at AWADDR 0x100, AWLEN=4, WLAST on beat 4 -> WREADY on all 4, one BVALID with BID=0, protocol_err=0. Then AR 0x100 ARLEN=4 -> RDATA 0xA0..0xA3, RLAST only on beat 4, first RVALID 3 cycles after AR handshake.
- RREADY toggled 1,0,0,1,... during a 4-beat read -> RDATA/RLAST stable while stalled, no beat dropped or duplicated.
- AWVALID and ARVALID both raised in the same IDLE cycle, twice in succession -> first pair serves write first, second pair serves read first; ARREADY stays 0 until B completes.
- Burst at the top word index (depth-2) with LEN=4 -> beats 3 and 4 land at indices 0 and 1 (wrap); readback confirms.
- WLAST on beat 2 of AWLEN=4 -> 4 beats accepted, one B, protocol_err=1 and it stays set.
- rst_n pulled low during beat 2 of a read -> RVALID drops immediately, state IDLE. After release, a new AR is accepted with ARREADY in the first cycle.
